coreahblite_defaultslave_mc: RTL and testbench
==============================================

# coreahblite_defaultslave_mc

Multi-channel, parametrised AHB-Lite default slave for the CoreAHBLite matrix. It answers every data phase that no real slave decodes, independently for each master channel. Each channel runs either the two-cycle ERROR response or an OKAY response, preceded by a configurable number of wait states. A shared saturating counter tallies completed default responses for debug and status.

## Interface
- NUM_MASTERS, 2, number of independent master channels (1..16)
- WAIT_STATES, 0, OKAY-wait cycles inserted before the response (0..15)
- RESP_MODE, 0, 0 = two-cycle ERROR response, 1 = OKAY response
- ERR_COUNT_W, 8, width of ERRCOUNT (1..32)
- HCLK  in  1  clock; all state updates on the rising edge
- HRESETN  in  1  asynchronous, active-low reset
- DEFSLAVEDATASEL  in  NUM_MASTERS  bit i high: channel i data phase targets the default slave
- CLRERR  in  1  synchronous clear of ERRCOUNT
- DEFSLAVEDATAREADY  out  NUM_MASTERS  per-channel HREADYOUT contribution; reset value all 1
- HRESP_DEFAULT  out  NUM_MASTERS  per-channel HRESP, 1 = ERROR; reset value all 0
- ERRCOUNT  out  ERR_COUNT_W  completed default responses, saturating; reset value 0

## Operation
- The block uses one clock. Reset is asynchronous and active-low.
- While HRESETN is low:
  - every channel is in IDLE and its wait counter is 0;
  - ERRCOUNT is 0;
  - outputs are forced to READY=1, HRESP=0 regardless of SEL.
- Each channel is an independent FSM with states IDLE, WAIT, RESP1, RESP2 and a 4-bit wait counter.
- IDLE, SEL low: outputs READY=1, HRESP=0; stay in IDLE.
- IDLE, SEL high, outputs are Mealy, same cycle:
  - WAIT_STATES=0, RESP_MODE=0: READY=0, HRESP=1; next state RESP2.
  - WAIT_STATES=0, RESP_MODE=1: READY=1, HRESP=0; stay in IDLE. This cycle is a completion.
  - WAIT_STATES=1: READY=0, HRESP=0; next state RESP1 if RESP_MODE=0, else RESP2.
  - WAIT_STATES>1: READY=0, HRESP=0; load counter with WAIT_STATES-1; next state WAIT.
- WAIT: outputs READY=0, HRESP=0.
  - Counter equal to 1: next state RESP1 (RESP_MODE=0) or RESP2 (RESP_MODE=1).
  - Otherwise: decrement the counter and stay in WAIT.
- RESP1: outputs READY=0, HRESP=1; next state RESP2.
- RESP2: outputs READY=1, HRESP equal to ~RESP_MODE; next state IDLE. This cycle is a completion.
- SEL is ignored in WAIT, RESP1 and RESP2. SEL still high in RESP2 does not re-arm the FSM; SEL high in the following IDLE cycle starts a new response.
- ERRCOUNT update at each clock edge:
  - CLRERR high: ERRCOUNT becomes 0. Clear wins over any same-cycle completions.
  - Otherwise ERRCOUNT becomes min(ERRCOUNT + number of completions this cycle, 2^ERR_COUNT_W - 1).
  - The sum is computed at width ERR_COUNT_W+5 before saturation, so no wrap-around is possible.

## Timing
- Data-phase length per default-slave transfer:
  - ERROR mode: WAIT_STATES+2 cycles. HRESP is high for the final 2 cycles; READY is high only in the last cycle.
  - OKAY mode: WAIT_STATES+1 cycles (WAIT_STATES=0 gives a single zero-wait cycle).
- Configuration WAIT_STATES=0, RESP_MODE=0 is cycle-identical to the single-channel two-cycle default slave.
- Zero-wait OKAY mode accepts back-to-back SEL on consecutive cycles; each high cycle counts as one completion.
- ERRCOUNT lags a completion by one clock.
- Channels never interact, except through simultaneous increments of ERRCOUNT.
- Reset asserted mid-response returns the channel to IDLE immediately. That response is not counted.

## Structure
- A shared package or include holds:
  - the state encoding localparams (IDLE=2'd0, WAIT=2'd1, RESP1=2'd2, RESP2=2'd3);
  - the response-mode constants RESP_ERROR=1'b0 and RESP_OKAY=1'b1.
- One sub-module, coreahblite_defaultslave_chan, implements a single channel FSM and its wait counter. It takes WAIT_STATES and RESP_MODE as parameters and outputs a one-bit completion pulse.
- The top level instantiates NUM_MASTERS channels with a generate loop. It adds the completion popcount and the saturating ERRCOUNT register.

## Test plan
- Default parameters, SEL[0] high for 2 cycles:
  - ch0 gives READY 0,1 and HRESP 1,1, then READY=1, HRESP=0;
  - ERRCOUNT reaches 1 one clock after the second cycle;
  - ch1 stays at READY=1, HRESP=0 throughout.
- WAIT_STATES=3, RESP_MODE=0, SEL[1] high: READY 0,0,0,0,1 and HRESP 0,0,0,1,1.
- RESP_MODE=1, WAIT_STATES=0, SEL[0] high for 4 cycles: READY stays at 1 and HRESP at 0; ERRCOUNT goes 1,2,3,4.
- NUM_MASTERS=4, all SEL bits high in the same cycle with default mode: all four channels respond identically and ERRCOUNT increments by 4 at once.
- ERR_COUNT_W=2, run 5 ERROR responses: ERRCOUNT saturates at 3. CLRERR asserted in the same cycle as a completion: ERRCOUNT becomes 0.
- HRESETN dropped during RESP1 with WAIT_STATES=2:
  - outputs go to READY=1, HRESP=0 immediately and ERRCOUNT goes to 0;
  - after release, a new SEL starts a full response from IDLE.

Source files
------------

// File: rtl/coreahblite_defaultslave_pkg.sv
// Shared encodings for the multi-channel AHB-Lite default slave: channel FSM
// states, response-mode constants and the ERRCOUNT guard width.
package coreahblite_defaultslave_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] RESP1 = 2'd2;
   localparam logic [1:0] RESP2 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_WAIT  = WAIT,
      ST_RESP1 = RESP1,
      ST_RESP2 = RESP2
   } chan_state_e;

   localparam logic RESP_ERROR = 1'b0;
   localparam logic RESP_OKAY  = 1'b1;

   // Extra bits on the ERRCOUNT adder: 16 channels can complete at once.
   localparam int CNT_GUARD_W = 5;

endpackage

// File: rtl/coreahblite_defaultslave_chan.sv
// One default-slave channel: answers a data phase with optional wait states
// followed by either the two-cycle ERROR response or an OKAY response.
module coreahblite_defaultslave_chan
   import coreahblite_defaultslave_pkg::*;
#(
   parameter int WAIT_STATES = 0,
   parameter int RESP_MODE   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sel,
   output logic        ready,
   output logic        resp,
   output logic        done,
   output chan_state_e state
);

   localparam logic       MODE       = (RESP_MODE != 0) ? RESP_OKAY : RESP_ERROR;
   localparam chan_state_e AFTER_WAIT = (MODE == RESP_ERROR) ? ST_RESP1 : ST_RESP2;
   localparam logic [3:0] WS_LOAD    = (WAIT_STATES > 1) ? 4'(WAIT_STATES - 1) : 4'd0;

   chan_state_e state_next;
   logic [3:0]  wait_cnt;
   logic [3:0]  wait_cnt_next;
   logic        ready_raw;
   logic        resp_raw;
   logic        done_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      ready_raw     = 1'b1;
      resp_raw      = 1'b0;
      done_raw      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sel) begin
               if (WAIT_STATES == 0) begin
                  if (MODE == RESP_ERROR) begin
                     ready_raw  = 1'b0;
                     resp_raw   = 1'b1;
                     state_next = ST_RESP2;
                  end else begin
                     // Zero-wait OKAY completes in the address-decoded cycle itself.
                     done_raw = 1'b1;
                  end
               end else if (WAIT_STATES == 1) begin
                  ready_raw  = 1'b0;
                  state_next = AFTER_WAIT;
               end else begin
                  ready_raw     = 1'b0;
                  wait_cnt_next = WS_LOAD;
                  state_next    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            ready_raw = 1'b0;
            if (wait_cnt == 4'd1) begin
               state_next = AFTER_WAIT;
            end else begin
               wait_cnt_next = wait_cnt - 4'd1;
            end
         end
         ST_RESP1: begin
            ready_raw  = 1'b0;
            resp_raw   = 1'b1;
            state_next = ST_RESP2;
         end
         ST_RESP2: begin
            ready_raw  = 1'b1;
            resp_raw   = ~MODE;
            done_raw   = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Mealy IDLE outputs would follow SEL during reset; force the idle response.
   assign ready = ready_raw | ~rst_n;
   assign resp  = resp_raw & rst_n;
   assign done  = done_raw & rst_n;

endmodule

// File: rtl/coreahblite_defaultslave_mc.sv
// Multi-channel AHB-Lite default slave: one independent responder per master
// channel plus a shared saturating count of completed default responses.
module coreahblite_defaultslave_mc
   import coreahblite_defaultslave_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int WAIT_STATES = 0,
   parameter int RESP_MODE   = 0,
   parameter int ERR_COUNT_W = 8
) (
   input  logic                     HCLK,
   input  logic                     HRESETN,
   input  logic [NUM_MASTERS-1:0]   DEFSLAVEDATASEL,
   input  logic                     CLRERR,
   output logic [NUM_MASTERS-1:0]   DEFSLAVEDATAREADY,
   output logic [NUM_MASTERS-1:0]   HRESP_DEFAULT,
   output logic [ERR_COUNT_W-1:0]   ERRCOUNT,
   output logic [2*NUM_MASTERS-1:0] dbg_state
);

   localparam int SUM_W = ERR_COUNT_W + CNT_GUARD_W;
   localparam logic [SUM_W-1:0] CNT_MAX = {{CNT_GUARD_W{1'b0}}, {ERR_COUNT_W{1'b1}}};

   // Handshake: a channel's data phase is held by SEL; it ends in the cycle
   // where READY is high, and HRESP qualifies that cycle (and the one before).
   logic [NUM_MASTERS-1:0] done;
   chan_state_e            chan_state [NUM_MASTERS];
   logic [SUM_W-1:0]       pop;
   logic [SUM_W-1:0]       cnt_sum;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_chan
      coreahblite_defaultslave_chan #(
         .WAIT_STATES (WAIT_STATES),
         .RESP_MODE   (RESP_MODE)
      ) u_chan (
         .clk   (HCLK),
         .rst_n (HRESETN),
         .sel   (DEFSLAVEDATASEL[i]),
         .ready (DEFSLAVEDATAREADY[i]),
         .resp  (HRESP_DEFAULT[i]),
         .done  (done[i]),
         .state (chan_state[i])
      );
      assign dbg_state[2*i +: 2] = chan_state[i];
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         pop = pop + SUM_W'(done[i]);
      end
   end

   assign cnt_sum = {{CNT_GUARD_W{1'b0}}, ERRCOUNT} + pop;

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         ERRCOUNT <= '0;
      end else if (CLRERR) begin
         ERRCOUNT <= '0;
      end else if (cnt_sum > CNT_MAX) begin
         ERRCOUNT <= '1;
      end else begin
         ERRCOUNT <= cnt_sum[ERR_COUNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_coreahblite_defaultslave_mc.sv
// Bench for coreahblite_defaultslave_mc: six parameter sets side by side,
// a vector table, directed corner sequences and random traffic against a model.
module tb_coreahblite_defaultslave_mc;

   localparam int ND = 6;
   localparam int NM_C [ND] = '{2, 2, 2, 4, 2, 3};
   localparam int WS_C [ND] = '{0, 3, 0, 0, 2, 1};
   localparam int RM_C [ND] = '{0, 0, 1, 0, 0, 1};
   localparam int CW_C [ND] = '{8, 8, 8, 2, 8, 4};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0] sel     [ND];
   logic       clr     [ND];
   logic [3:0] rdy_all [ND];
   logic [3:0] rsp_all [ND];
   logic [7:0] cnt_all [ND];
   logic [7:0] dbg_all [ND];

   for (genvar k = 0; k < ND; k++) begin : g_dut
      localparam int NM = NM_C[k];
      localparam int CW = CW_C[k];
      logic [NM-1:0]   rdy;
      logic [NM-1:0]   rsp;
      logic [CW-1:0]   cnt;
      logic [2*NM-1:0] dbg;
      coreahblite_defaultslave_mc #(
         .NUM_MASTERS (NM),
         .WAIT_STATES (WS_C[k]),
         .RESP_MODE   (RM_C[k]),
         .ERR_COUNT_W (CW)
      ) u_dut (
         .HCLK              (clk),
         .HRESETN           (rst_n),
         .DEFSLAVEDATASEL   (sel[k][NM-1:0]),
         .CLRERR            (clr[k]),
         .DEFSLAVEDATAREADY (rdy),
         .HRESP_DEFAULT     (rsp),
         .ERRCOUNT          (cnt),
         .dbg_state         (dbg)
      );
      assign rdy_all[k] = 4'(rdy);
      assign rsp_all[k] = 4'(rsp);
      assign cnt_all[k] = 8'(cnt);
      assign dbg_all[k] = 8'(dbg);
   end

   // ---------------- scoreboard / model ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   bit         m_busy [ND][4];
   int         m_pos  [ND][4];
   int         m_cnt  [ND];
   logic [3:0] s_rdy  [ND];
   logic [3:0] s_rsp  [ND];
   logic [7:0] s_cnt  [ND];

   // Transfer length in cycles: ERROR = WAIT_STATES+2, OKAY = WAIT_STATES+1.
   function automatic int xfer_len(int k);
      return (RM_C[k] == 0) ? WS_C[k] + 2 : WS_C[k] + 1;
   endfunction

   function automatic int all_ones(int w);
      return (1 << w) - 1;
   endfunction

   task automatic check(string name, int k, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s dut=%0d cyc=%0d got %0d exp %0d", name, k, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < ND; k++) begin
         m_cnt[k] = 0;
         for (int c = 0; c < 4; c++) begin
            m_busy[k][c] = 1'b0;
            m_pos[k][c]  = 0;
         end
      end
   endtask

   // Called just after a falling edge with inputs already driven: samples and
   // checks every output, advances the model over the rising edge.
   task automatic step();
      int  done_n [ND];
      int  len;
      int  p;
      bit  active;
      bit  e_rdy;
      bit  e_rsp;
      #1;
      for (int k = 0; k < ND; k++) begin
         s_rdy[k]  = rdy_all[k];
         s_rsp[k]  = rsp_all[k];
         s_cnt[k]  = cnt_all[k];
         done_n[k] = 0;
         len       = xfer_len(k);
         for (int c = 0; c < NM_C[k]; c++) begin
            active = m_busy[k][c] || sel[k][c];
            p      = m_busy[k][c] ? m_pos[k][c] : 0;
            if (active) begin
               e_rdy = (p == len - 1);
               e_rsp = (RM_C[k] == 0) && (p >= len - 2);
            end else begin
               e_rdy = 1'b1;
               e_rsp = 1'b0;
            end
            check($sformatf("ready ch%0d", c), k, int'(rdy_all[k][c]), int'(e_rdy));
            check($sformatf("hresp ch%0d", c), k, int'(rsp_all[k][c]), int'(e_rsp));
            if (active) begin
               if (p == len - 1) begin
                  done_n[k]++;
                  m_busy[k][c] = 1'b0;
               end else begin
                  m_busy[k][c] = 1'b1;
                  m_pos[k][c]  = p + 1;
               end
            end
         end
         check("errcount", k, int'(cnt_all[k]), m_cnt[k]);
      end
      @(posedge clk);
      for (int k = 0; k < ND; k++) begin
         if (clr[k]) m_cnt[k] = 0;
         else if (m_cnt[k] + done_n[k] > all_ones(CW_C[k])) m_cnt[k] = all_ones(CW_C[k]);
         else m_cnt[k] = m_cnt[k] + done_n[k];
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle_all();
      for (int k = 0; k < ND; k++) begin
         sel[k] = 4'd0;
         clr[k] = 1'b0;
      end
   endtask

   // ---------------- vector table for the default configuration ----------------
   typedef struct {
      logic [1:0] sel;
      logic       clr;
      logic [1:0] rdy;
      logic [1:0] rsp;
      logic [7:0] cnt;
   } vec_t;

   vec_t vt [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{sel: 2'b01, clr: 1'b0, rdy: 2'b10, rsp: 2'b01, cnt: 8'd0};
      vt[1] = '{sel: 2'b01, clr: 1'b0, rdy: 2'b11, rsp: 2'b01, cnt: 8'd0};
      vt[2] = '{sel: 2'b00, clr: 1'b0, rdy: 2'b11, rsp: 2'b00, cnt: 8'd1};
      vt[3] = '{sel: 2'b10, clr: 1'b0, rdy: 2'b01, rsp: 2'b10, cnt: 8'd1};
      vt[4] = '{sel: 2'b00, clr: 1'b0, rdy: 2'b11, rsp: 2'b10, cnt: 8'd1};
      vt[5] = '{sel: 2'b11, clr: 1'b0, rdy: 2'b00, rsp: 2'b11, cnt: 8'd2};
      vt[6] = '{sel: 2'b11, clr: 1'b0, rdy: 2'b11, rsp: 2'b11, cnt: 8'd2};
      vt[7] = '{sel: 2'b11, clr: 1'b0, rdy: 2'b00, rsp: 2'b11, cnt: 8'd4};
      vt[8] = '{sel: 2'b00, clr: 1'b1, rdy: 2'b11, rsp: 2'b11, cnt: 8'd4};
      vt[9] = '{sel: 2'b00, clr: 1'b0, rdy: 2'b11, rsp: 2'b00, cnt: 8'd0};

      // Reset with SEL held high: outputs must still show the idle response.
      rst_n = 1'b0;
      for (int k = 0; k < ND; k++) begin
         sel[k] = 4'hF;
         clr[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < ND; k++) begin
         check("reset ready", k, int'(rdy_all[k]), all_ones(NM_C[k]));
         check("reset hresp", k, int'(rsp_all[k]), 0);
         check("reset errcount", k, int'(cnt_all[k]), 0);
         check("reset state", k, int'(dbg_all[k]), 0);
      end
      idle_all();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Table: default parameters.
      for (int i = 0; i < 10; i++) begin
         sel[0] = {2'b00, vt[i].sel};
         clr[0] = vt[i].clr;
         step();
         check($sformatf("tbl%0d ready", i), 0, int'(s_rdy[0]), int'(vt[i].rdy));
         check($sformatf("tbl%0d hresp", i), 0, int'(s_rsp[0]), int'(vt[i].rsp));
         check($sformatf("tbl%0d errcount", i), 0, int'(s_cnt[0]), int'(vt[i].cnt));
      end
      idle_all();

      // WAIT_STATES=3 ERROR on channel 1.
      begin
         logic [4:0] exp_r;
         logic [4:0] exp_h;
         exp_r = 5'b10000;
         exp_h = 5'b11000;
         for (int i = 0; i < 5; i++) begin
            sel[1] = (i == 0) ? 4'b0010 : 4'b0000;
            step();
            check($sformatf("ws3 ready%0d", i), 1, int'(s_rdy[1][1]), int'(exp_r[i]));
            check($sformatf("ws3 hresp%0d", i), 1, int'(s_rsp[1][1]), int'(exp_h[i]));
         end
         step();
         check("ws3 errcount", 1, int'(s_cnt[1]), 1);
      end

      // Zero-wait OKAY, back-to-back SEL for 4 cycles.
      for (int i = 0; i < 5; i++) begin
         sel[2] = (i < 4) ? 4'b0001 : 4'b0000;
         step();
         if (i < 4) begin
            check($sformatf("okay ready%0d", i), 2, int'(s_rdy[2][0]), 1);
            check($sformatf("okay hresp%0d", i), 2, int'(s_rsp[2][0]), 0);
         end
         if (i > 0) check($sformatf("okay errcount%0d", i), 2, int'(s_cnt[2]), i);
      end
      sel[2] = 4'd0;

      // Four channels at once, 2-bit counter: +4 saturates at 3.
      sel[3] = 4'hF;
      step();
      check("all4 ready", 3, int'(s_rdy[3]), 0);
      check("all4 hresp", 3, int'(s_rsp[3]), 15);
      sel[3] = 4'h0;
      step();
      check("all4 ready end", 3, int'(s_rdy[3]), 15);
      check("all4 hresp end", 3, int'(s_rsp[3]), 15);
      step();
      check("all4 sat", 3, int'(s_cnt[3]), 3);
      clr[3] = 1'b1;
      step();
      clr[3] = 1'b0;
      for (int r = 0; r < 5; r++) begin
         sel[3] = 4'b0001;
         step();
         sel[3] = 4'b0000;
         step();
      end
      step();
      check("five sat", 3, int'(s_cnt[3]), 3);
      // Clear in the same cycle as a completion.
      sel[3] = 4'b0001;
      step();
      sel[3] = 4'b0000;
      clr[3] = 1'b1;
      step();
      clr[3] = 1'b0;
      step();
      check("clr wins", 3, int'(s_cnt[3]), 0);

      // Random traffic on every configuration.
      for (int n = 0; n < 800; n++) begin
         for (int k = 0; k < ND; k++) begin
            sel[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            clr[k] = ($urandom_range(0, 19) == 0);
         end
         step();
      end
      idle_all();
      repeat (6) step();

      // Reset during RESP1 with WAIT_STATES=2.
      sel[4] = 4'b0001;
      step();
      sel[4] = 4'b0000;
      step();
      #1;
      check("pre-reset ready", 4, int'(rdy_all[4][0]), 0);
      check("pre-reset hresp", 4, int'(rsp_all[4][0]), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst ready", 4, int'(rdy_all[4]), 3);
      check("midrst hresp", 4, int'(rsp_all[4]), 0);
      check("midrst errcount", 4, int'(cnt_all[4]), 0);
      check("midrst state", 4, int'(dbg_all[4]), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic [3:0] exp_r;
         logic [3:0] exp_h;
         exp_r = 4'b1000;
         exp_h = 4'b1100;
         for (int i = 0; i < 4; i++) begin
            sel[4] = (i == 0) ? 4'b0001 : 4'b0000;
            step();
            check($sformatf("postrst ready%0d", i), 4, int'(s_rdy[4][0]), int'(exp_r[i]));
            check($sformatf("postrst hresp%0d", i), 4, int'(s_rsp[4][0]), int'(exp_h[i]));
         end
         step();
         check("postrst errcount", 4, int'(s_cnt[4]), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
